program_encoder: RTL

PROGRAM_ENCODER -- requirements
Module: program_encoder

---
 rtl/program_encoder_pkg.sv | 42 ++++
 rtl/program_encoder_fifo.sv | 48 ++++
 rtl/program_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/program_encoder_pkg.sv
// Shared constants for the RV32I program encoder:
// instruction classes, opcodes, funct fields and the NOP word.
package program_encoder_pkg;

    localparam logic [3:0] CLS_R     = 4'd0;
    localparam logic [3:0] CLS_I     = 4'd1;
    localparam logic [3:0] CLS_LW    = 4'd2;
    localparam logic [3:0] CLS_SW    = 4'd3;
    localparam logic [3:0] CLS_BR    = 4'd4;
    localparam logic [3:0] CLS_JAL   = 4'd5;
    localparam logic [3:0] CLS_JALR  = 4'd6;
    localparam logic [3:0] CLS_LUI   = 4'd7;
    localparam logic [3:0] CLS_AUIPC = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0]  F7_ALT = 7'b0100000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/program_encoder_fifo.sv
// Two-entry synchronous FIFO between the encoder and the
// instruction-memory write port.
module sync_fifo2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [2];
    logic          wp_q;
    logic          rp_q;
    logic [1:0]    cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= !wp_q;
            end
            if (do_pop) begin
                rp_q <= !rp_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/program_encoder.sv
// RV32I program encoder: packs instruction fields into words and
// streams them to instruction memory through a 2-deep FIFO.
module program_encoder
    import program_encoder_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cls,
    input  logic [2:0]    in_funct3,
    input  logic          in_alt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          in_last,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW:0]    count_q, count_d;
    logic           err_q, err_d;

    logic [31:0]    enc_word;
    logic           enc_ill;
    logic [6:0]     alt_f7;
    logic           shift_f3;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    // Handshakes are masked while reset is held so nothing moves that cycle.
    assign in_ready = !reset && (state_q == S_LOAD) && !full;
    assign push     = in_valid && in_ready;
    assign wr_valid = !reset && !empty;
    assign pop      = wr_valid && wr_ready;
    assign wr_addr  = addr_q;
    assign count    = count_q;
    assign err      = err_q;

    always_comb begin
        enc_ill  = 1'b0;
        enc_word = NOP;
        alt_f7   = in_alt ? F7_ALT : 7'd0;
        shift_f3 = (in_funct3 == F3_SLL) || (in_funct3 == F3_SR);
        unique case (in_cls)
            CLS_R: enc_word = {
                (in_funct3 == F3_ADD || in_funct3 == F3_SR) ? alt_f7 : 7'd0,
                in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            CLS_I: enc_word = {
                shift_f3 ? {alt_f7, in_imm[4:0]} : in_imm[11:0],
                in_rs1, in_funct3, in_rd, OP_I};
            CLS_LW: enc_word = {
                in_imm[11:0], in_rs1, F3_W, in_rd, OP_LOAD};
            CLS_SW: enc_word = {
                in_imm[11:5], in_rs2, in_rs1, F3_W,
                in_imm[4:0], OP_STORE};
            CLS_BR: begin
                if (in_funct3 == F3_BLT || in_funct3 == F3_BGE) begin
                    enc_word = {
                        in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                        in_funct3, in_imm[4:1], in_imm[11], OP_BRANCH};
                end else begin
                    enc_ill = 1'b1;
                end
            end
            CLS_JAL: enc_word = {
                in_imm[20], in_imm[10:1], in_imm[11],
                in_imm[19:12], in_rd, OP_JAL};
            CLS_JALR: enc_word = {
                in_imm[11:0], in_rs1, F3_JALR, in_rd, OP_JALR};
            CLS_LUI:   enc_word = {in_imm[31:12], in_rd, OP_LUI};
            CLS_AUIPC: enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
            default:   enc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        done    = 1'b0;
        if (pop) begin
            addr_d = addr_q + 1'b1;
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end
        if (push && enc_ill) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (push && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = S_IDLE;
                    done    = !reset;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    sync_fifo2 #(
        .DW(32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (enc_word),
        .dout_o  (wr_data),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
